// File: rtl/fetch_unit.sv
// Instruction fetch front end for the 16-bit pipeline.
// It issues sequential word reads to a synchronous instruction memory with a
// 1-cycle read latency. Returned words go into a small circular prefetch queue,
// so that decode stalls never drop a fetched instruction. The unit also handles
// branch redirects from execute and stops fetching once a HALT word returns.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  OPC_HALT = 4'hF,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_to_new,
  input  logic [15:0] branch_pc,
  output logic [15:0] imem_addr,
  output logic        imem_rden,
  input  logic [15:0] imem_q,
  output logic [15:0] pc,
  output logic [15:0] inst,
  output logic        inst_valid,
  output logic        halted
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  // Occupancy (count + inflight) needs one extra bit of headroom.
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  // Architectural state
  logic [15:0]      fetch_pc_q, fetch_pc_d;
  logic             inflight_q, inflight_d;
  logic [15:0]      inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q, halted_d;

  // Queue storage: one {pc, inst} pair per entry
  logic [15:0] entry_pc_q   [DEPTH];
  logic [15:0] entry_inst_q [DEPTH];

  // Control decisions for the current cycle
  logic [CNT_W:0] occupancy;
  logic           queue_nonempty;
  logic           halt_push;
  logic           issue;
  logic           push;
  logic           pop;

  // Control decode: a slot is reserved for every read in flight, so a
  // returning word can always be pushed without a full check.
  always_comb begin
    occupancy      = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
    queue_nonempty = (count_q != '0);
    halt_push      = inflight_q && (imem_q[15:12] == OPC_HALT) && !branch_to_new;
    issue          = !rst && !halted_q && !branch_to_new && !halt_push &&
                     (occupancy < DEPTH_OCC);
    // A redirect discards the returning word and leaves the head untouched,
    // because the whole queue is about to be flushed.
    push           = inflight_q && !branch_to_new;
    pop            = queue_nonempty && !stall && !branch_to_new;
  end

  // Next-state logic for PC, in-flight tracking, queue pointers and halt flag
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    halted_d      = halted_q;

    if (issue) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 16'd1;  // natural 16-bit wrap FFFF -> 0000
    end

    if (branch_to_new) begin
      // A redirect flushes everything and restarts fetch, even from halt.
      fetch_pc_d = branch_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      halted_d   = 1'b0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (halt_push) begin
        halted_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset taking priority over all updates
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 16'h0000;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      halted_q      <= halted_d;
    end
  end

  // Per-entry storage write: the tail entry captures the returning word.
  // Storage needs no reset, because validity is tracked by count_q alone.
  generate
    for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_entry
      // Capture {inflight_pc, imem_q} when this entry is the tail
      always_ff @(posedge clk) begin
        if (!rst && push && (tail_q == PTR_W'(gi))) begin
          entry_pc_q[gi]   <= inflight_pc_q;
          entry_inst_q[gi] <= imem_q;
        end
      end
    end
  endgenerate

  // Outputs: the queue head only (no bypass from the memory return path)
  always_comb begin
    imem_rden  = issue;
    imem_addr  = fetch_pc_q;
    inst_valid = queue_nonempty;
    halted     = halted_q;
    pc         = 16'h0000;
    inst       = NOP_INST;
    if (queue_nonempty) begin
      pc   = entry_pc_q[head_q];
      inst = entry_inst_q[head_q];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. It covers reset, streaming, stall
// back-pressure, branch flush, HALT, branch out of halt, PC wrap and reset
// applied mid-stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_to_new;
  logic [15:0] branch_pc;
  logic [15:0] imem_addr;
  logic        imem_rden;
  logic [15:0] imem_q = 16'h0000;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        inst_valid;
  logic        halted;

  logic [15:0] imem [0:65535];

  int errors = 0;
  int checks = 0;
  int cyc    = -3;

  fetch_unit #(
    .DEPTH(4), .RESET_PC(16'h0000), .OPC_HALT(4'hF), .NOP_INST(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_to_new(branch_to_new),
    .branch_pc(branch_pc), .imem_addr(imem_addr), .imem_rden(imem_rden),
    .imem_q(imem_q), .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory with 1-cycle latency
  always @(posedge clk) begin
    if (imem_rden) imem_q <= imem[imem_addr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL c%0d %s: observed=%h expected=%h", cyc, tag, obs, exp_v);
    end
  endtask

  // Advance one cycle: drive the inputs for the new cycle, then let them settle
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] bp);
    @(posedge clk);
    #1;
    rst = r; stall = s; branch_to_new = b; branch_pc = bp;
    cyc++;
    #1;
  endtask

  task automatic exp_q(input logic v, input logic [15:0] p, input logic [15:0] i);
    chk("inst_valid", 16'(inst_valid), 16'(v));
    if (v) begin
      chk("pc", pc, p);
      chk("inst", inst, i);
    end else begin
      chk("inst_nop", inst, 16'h0000);
    end
  endtask

  task automatic exp_rd(input logic r, input logic [15:0] a);
    chk("imem_rden", 16'(imem_rden), 16'(r));
    if (r) chk("imem_addr", imem_addr, a);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) imem[a] = 16'h7000 ^ {4'h0, a[11:0]};
    imem[0] = 16'h1111; imem[1] = 16'h2222; imem[2] = 16'h3333; imem[3] = 16'h4444;
    rst = 1'b1; stall = 1'b0; branch_to_new = 1'b0; branch_pc = 16'h0000;

    // Reset state
    step(1, 0, 0, 16'h0); step(1, 0, 0, 16'h0);
    exp_q(0, 0, 0); exp_rd(0, 0); chk("halted", 16'(halted), 16'd0);
    chk("pc_reset", pc, 16'h0000);

    // Test 1: streaming after reset
    step(0, 0, 0, 16'h0); exp_q(0, 0, 0);               exp_rd(1, 16'h0000);   // c0
    step(0, 0, 0, 16'h0); exp_q(0, 0, 0);               exp_rd(1, 16'h0001);   // c1
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0000, 16'h1111); exp_rd(1, 16'h0002);   // c2

    // Test 2: stall for 8 cycles (c3..c10)
    step(0, 1, 0, 16'h0); exp_q(1, 16'h0001, 16'h2222); exp_rd(1, 16'h0003);   // c3
    step(0, 1, 0, 16'h0); exp_q(1, 16'h0001, 16'h2222); exp_rd(1, 16'h0004);   // c4
    step(0, 1, 0, 16'h0); exp_q(1, 16'h0001, 16'h2222); exp_rd(0, 16'h0);      // c5
    for (int k = 0; k < 5; k++) begin                                         // c6..c10
      step(0, 1, 0, 16'h0); exp_q(1, 16'h0001, 16'h2222); exp_rd(0, 16'h0);
    end
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0001, 16'h2222); exp_rd(0, 16'h0);      // c11
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0002, 16'h3333); exp_rd(1, 16'h0005);   // c12
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0003, 16'h4444); exp_rd(1, 16'h0006);   // c13

    // Test 3: branch with 2 queued entries and one read in flight
    step(0, 0, 1, 16'h0040); exp_q(1, 16'h0004, 16'h7004); exp_rd(0, 16'h0);   // c14
    step(0, 0, 0, 16'h0); exp_q(0, 0, 0);               exp_rd(1, 16'h0040);   // c15
    step(0, 0, 0, 16'h0); exp_q(0, 0, 0);               exp_rd(1, 16'h0041);   // c16
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0040, 16'h7040); exp_rd(1, 16'h0042);   // c17
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0041, 16'h7041); exp_rd(1, 16'h0043);   // c18

    // Test 4: HALT at address 5, then branch out of halt
    imem[5] = 16'hF000;
    step(0, 0, 1, 16'h0004); exp_q(1, 16'h0042, 16'h7042); exp_rd(0, 16'h0);   // c19
    step(0, 0, 0, 16'h0); exp_q(0, 0, 0);               exp_rd(1, 16'h0004);   // c20
    step(0, 0, 0, 16'h0); exp_q(0, 0, 0);               exp_rd(1, 16'h0005);   // c21
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0004, 16'h7004); exp_rd(0, 16'h0);      // c22
    chk("halted_pre", 16'(halted), 16'd0);
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0005, 16'hF000); exp_rd(0, 16'h0);      // c23
    chk("halted_set", 16'(halted), 16'd1);
    step(0, 0, 0, 16'h0); exp_q(0, 0, 0); exp_rd(0, 16'h0); chk("halted", 16'(halted), 16'd1);
    step(0, 0, 0, 16'h0); exp_q(0, 0, 0); exp_rd(0, 16'h0); chk("halted", 16'(halted), 16'd1);
    step(0, 0, 1, 16'h0010); exp_q(0, 0, 0); exp_rd(0, 16'h0);                 // c26
    step(0, 0, 0, 16'h0); exp_q(0, 0, 0); exp_rd(1, 16'h0010);                 // c27
    chk("halted_clr", 16'(halted), 16'd0);
    step(0, 0, 0, 16'h0); exp_q(0, 0, 0);               exp_rd(1, 16'h0011);   // c28
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0010, 16'h7010); exp_rd(1, 16'h0012);   // c29
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0011, 16'h7011); exp_rd(1, 16'h0013);   // c30

    // Test 5: PC wrap from FFFE
    step(0, 0, 1, 16'hFFFE); exp_q(1, 16'h0012, 16'h7012); exp_rd(0, 16'h0);   // c31
    step(0, 0, 0, 16'h0); exp_q(0, 0, 0);               exp_rd(1, 16'hFFFE);   // c32
    step(0, 0, 0, 16'h0); exp_q(0, 0, 0);               exp_rd(1, 16'hFFFF);   // c33
    step(0, 0, 0, 16'h0); exp_q(1, 16'hFFFE, 16'h7FFE); exp_rd(1, 16'h0000);   // c34
    step(0, 0, 0, 16'h0); exp_q(1, 16'hFFFF, 16'h7FFF); exp_rd(1, 16'h0001);   // c35
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0000, 16'h1111); exp_rd(1, 16'h0002);   // c36
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0001, 16'h2222); exp_rd(1, 16'h0003);   // c37

    // Test 6: fill the queue under stall, then reset mid-stream
    step(0, 1, 0, 16'h0); exp_q(1, 16'h0002, 16'h3333); exp_rd(1, 16'h0004);   // c38
    step(0, 1, 0, 16'h0); exp_q(1, 16'h0002, 16'h3333); exp_rd(1, 16'h0005);   // c39
    for (int k = 0; k < 5; k++) begin                                         // c40..c44
      step(0, 1, 0, 16'h0); exp_q(1, 16'h0002, 16'h3333); exp_rd(0, 16'h0);
    end
    step(1, 1, 0, 16'h0); exp_rd(0, 16'h0);                                    // c45
    step(0, 1, 0, 16'h0); exp_q(0, 0, 0); exp_rd(1, 16'h0000);                 // c46
    chk("halted_rst", 16'(halted), 16'd0);
    step(0, 1, 0, 16'h0); exp_q(0, 0, 0);               exp_rd(1, 16'h0001);   // c47
    step(0, 1, 0, 16'h0); exp_q(1, 16'h0000, 16'h1111); exp_rd(1, 16'h0002);   // c48
    step(0, 1, 0, 16'h0); exp_q(1, 16'h0000, 16'h1111); exp_rd(1, 16'h0003);   // c49
    step(0, 1, 0, 16'h0); exp_q(1, 16'h0000, 16'h1111); exp_rd(0, 16'h0);      // c50
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0000, 16'h1111); exp_rd(0, 16'h0);      // c51
    step(0, 0, 0, 16'h0); exp_q(1, 16'h0001, 16'h2222); exp_rd(1, 16'h0004);   // c52

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end of the 16-bit pipeline. Feeds the IF/ID pipe registers that sit upstream of decode.
- Generates the PC and drives a synchronous-read instruction memory with 1-cycle read latency.
- Buffers returned words in a small prefetch queue, so decode stalls do not lose fetched instructions.
- Handles branch redirect from execute and stops fetching at HALT.

Parameters:
- DEPTH, 4, prefetch queue entries; power of 2, minimum 2.
- RESET_PC, 16'h0000, PC fetched first after reset.
- OPC_HALT, 4'hF, value of inst[15:12] that identifies HALT.
- NOP_INST, 16'h0000, value driven on inst when the queue is empty.

Ports:
- clk, in, 1, system clock; all state updates on posedge.
- rst, in, 1, synchronous, active-high reset.
- stall, in, 1, downstream cannot accept an instruction this cycle.
- branch_to_new, in, 1, redirect request from execute; valid for 1 cycle.
- branch_pc, in, 16, redirect target; sampled when branch_to_new=1.
- imem_addr, out, 16, instruction memory read address (word address).
- imem_rden, out, 1, read issue strobe.
- imem_q, in, 16, read data; valid the cycle after imem_rden=1.
- pc, out, 16, PC of the queue-head instruction.
- inst, out, 16, queue-head instruction.
- inst_valid, out, 1, queue non-empty.
- halted, out, 1, fetch stopped on HALT.

Behaviour:
- Reset (rst=1 at posedge) takes priority over everything:
  - fetch_pc=RESET_PC; queue empty; in-flight flag cleared; halted=0.
  - Outputs read inst_valid=0, inst=NOP_INST, pc=0, imem_rden=0.
  - Reset mid-operation discards queue and in-flight read.
- State:
  - fetch_pc.
  - inflight flag plus inflight_pc.
  - Circular queue of {pc,inst} with head/tail pointers and count (width clog2(DEPTH)+1).
  - halted.
- Issue condition (combinational): issue = !rst && !halted && !branch_to_new && !halt_push && (count + inflight < DEPTH).
  - imem_rden=issue; imem_addr=fetch_pc.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1. 16-bit wrap: FFFF -> 0000.
  - With no issue, inflight<=0.
- Response: in the cycle inflight=1, {inflight_pc, imem_q} is pushed at the tail at the clock edge. The push is never blocked, because the issue rule reserves the slot.
- Output, with no bypass:
  - pc/inst = head entry; inst_valid = count!=0.
  - Pop at edge when inst_valid && !stall.
  - Push and pop in the same cycle leave count unchanged.
- Latency: issue at cycle N, data at N+1, inst_valid at N+2. After reset release, the first inst_valid appears 2 cycles later. Steady-state throughput is 1 instruction/cycle with stall=0.
- Stall: head holds stable; issue continues until count+inflight=DEPTH, then imem_rden=0.
- HALT:
  - halt_push = inflight && imem_q[15:12]==OPC_HALT && !branch_to_new.
  - The HALT word is pushed; halted<=1; no further issue.
  - Queued instructions, including HALT, still drain normally.
- Branch (branch_to_new=1), priority over halt, pop and push:
  - Queue cleared; the in-flight response that cycle is discarded.
  - fetch_pc<=branch_pc; halted<=0; no issue that cycle.
  - Next cycle issues branch_pc; its inst_valid appears 3 cycles after the branch cycle.
  - Branch while halted restarts fetching.
- Full queue with stall=1: count stays DEPTH, no issue, no overflow.
- Empty queue: no underflow; inst_valid=0 and pop is ignored.

Test Plan:
1. Reset with imem[0..3]=1111,2222,3333,4444, stall=0 -> imem_rden=1 at cycles 0..; inst_valid=1 from cycle 2 with (pc,inst)=(0,1111),(1,2222),(2,3333),(3,4444) on consecutive cycles.
2. Hold stall=1 from cycle 3 for 8 cycles -> head holds (1,2222); count reaches 4; imem_rden=0 once count+inflight=4. Release stall -> (2,3333)… in order, none dropped or duplicated.
3. Assert branch_to_new with branch_pc=0x0040 while a read is in flight and the queue holds 2 entries -> inst_valid=0 the next cycle; imem_addr=0x0040 the next cycle; first valid output is (0x0040, imem[0x40]) 3 cycles after the branch; no stale entry ever appears.
4. imem[5]=F000 (HALT) -> (5,F000) is output, halted=1, imem_rden stays 0, pc 6 is never output. Then branch_pc=0x0010 -> halted=0 and fetching resumes at 0x0010.
5. Branch to 0xFFFE -> outputs pc FFFE, FFFF, 0000, 0001 (wrap).
6. Assert rst for one cycle mid-stream with a full queue and stall=1 -> next cycle inst_valid=0 and halted=0; fetch restarts at RESET_PC.
